// File: rtl/id_regbank_if.sv
// -----------------------------------------------------------------------------
// id_regbank_if
// Bundles the bus-side signals of id_regbank. The clock and reset stay
// plain ports on the module itself.
//   write port : i_dunit_clk_en, i_wr_en, i_wr_addr, i_wr_data   (WB / debug unit)
//   read ports : i_rd_addr (packed NUM_RD x NB_ADDR), o_rd_data (packed NUM_RD x NB_REG)
//   dump port  : i_dump_start, i_dump_ready, o_dump_valid, o_dump_addr,
//                o_dump_data, o_dump_busy, o_dump_done
// Modports: master = pipeline / debug-unit side, slave = register bank.
// -----------------------------------------------------------------------------
interface id_regbank_if #(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 5,
    parameter int NUM_RD  = 2
);
    logic                      i_dunit_clk_en;
    logic                      i_wr_en;
    logic [NB_ADDR-1:0]        i_wr_addr;
    logic [NB_REG-1:0]         i_wr_data;
    logic [NUM_RD*NB_ADDR-1:0] i_rd_addr;
    logic [NUM_RD*NB_REG-1:0]  o_rd_data;
    logic                      i_dump_start;
    logic                      i_dump_ready;
    logic                      o_dump_valid;
    logic [NB_ADDR-1:0]        o_dump_addr;
    logic [NB_REG-1:0]         o_dump_data;
    logic                      o_dump_busy;
    logic                      o_dump_done;

    modport master (
        output i_dunit_clk_en, i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
               i_dump_start, i_dump_ready,
        input  o_rd_data, o_dump_valid, o_dump_addr, o_dump_data,
               o_dump_busy, o_dump_done
    );

    modport slave (
        input  i_dunit_clk_en, i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
               i_dump_start, i_dump_ready,
        output o_rd_data, o_dump_valid, o_dump_addr, o_dump_data,
               o_dump_busy, o_dump_done
    );
endinterface

// File: rtl/id_regbank.sv
// -----------------------------------------------------------------------------
// id_regbank
// ID-stage register bank: 2**NB_ADDR registers of NB_REG bits, register 0
// hardwired to zero, NUM_RD combinational read ports with same-cycle
// write-to-read bypass, and a dump engine that streams every register to the
// debug unit over a valid/ready handshake.
//
// Ports:
//   i_clk    : clock, all state changes on the rising edge
//   i_reset  : synchronous reset, active low
//   bus      : id_regbank_if.slave (write, read and dump signals)
//
// Build option:
//   REGBANK_RESET_CLEAR_EN - when defined, reset also clears every register;
//                            otherwise the array keeps its contents over reset.
// -----------------------------------------------------------------------------
module id_regbank #(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 5,
    parameter int NUM_RD  = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    id_regbank_if.slave bus
);
    localparam int                 DEPTH    = 2 ** NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_IDX = '1;
    localparam logic [NB_ADDR-1:0] IDX_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_e;

    logic [NB_REG-1:0]        regs_q [DEPTH];
    logic                     wr_commit;
    logic [NUM_RD*NB_REG-1:0] rd_data_d;

    state_e                   state_q;
    logic                     dump_valid_q;
    logic                     dump_done_q;
    logic [NB_ADDR-1:0]       dump_addr_q;
    logic [NB_ADDR-1:0]       dump_addr_d;
    logic [NB_REG-1:0]        dump_data_q;
    logic [NB_REG-1:0]        dump_data_d;

    // Register 0 is never written, so its storage may stay X; every read
    // path forces it to zero instead.
    assign wr_commit = bus.i_wr_en & bus.i_dunit_clk_en & (bus.i_wr_addr != '0);

    // Value a reader at addr sees this cycle, including a committing write.
    function automatic logic [NB_REG-1:0] bypass_read(
        input logic [NB_ADDR-1:0] addr,
        input logic [NB_REG-1:0]  stored,
        input logic               commit,
        input logic [NB_ADDR-1:0] waddr,
        input logic [NB_REG-1:0]  wdata
    );
        if (addr == '0)
            return '0;
        else if (commit && (addr == waddr))
            return wdata;
        else
            return stored;
    endfunction

    // ---------------------------------------------------------------- storage
    // NOTE: the array gets a reset only when the build asks for it; a plain
    // register file without reset maps onto RAM/latch-array macros, a cleared
    // one forces flops.
    always_ff @(posedge i_clk) begin
`ifdef REGBANK_RESET_CLEAR_EN
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_commit) begin
            regs_q[bus.i_wr_addr] <= bus.i_wr_data;
        end
`else
        // NOTE: sequential state is always assigned with <= so every flop
        // samples pre-edge values regardless of block ordering.
        if (i_reset && wr_commit) regs_q[bus.i_wr_addr] <= bus.i_wr_data;
`endif
    end

    // ------------------------------------------------------------- read ports
    always_comb begin
        // NOTE: default first so no path through the block leaves a bit
        // unassigned, which would infer a latch.
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_d[k*NB_REG +: NB_REG] = bypass_read(
                bus.i_rd_addr[k*NB_ADDR +: NB_ADDR],
                regs_q[bus.i_rd_addr[k*NB_ADDR +: NB_ADDR]],
                wr_commit, bus.i_wr_addr, bus.i_wr_data);
        end
    end

    assign bus.o_rd_data = rd_data_d;

    // ------------------------------------------------------------ dump engine
    // Next word is captured with the bypass rule so a write committing in the
    // same cycle as the handshake is already reflected in the captured word.
    assign dump_addr_d = dump_addr_q + IDX_ONE;
    assign dump_data_d = bypass_read(dump_addr_d, regs_q[dump_addr_d],
                                     wr_commit, bus.i_wr_addr, bus.i_wr_data);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
        end else begin
            dump_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_dump_start) begin
                        state_q      <= ST_SEND;
                        dump_addr_q  <= '0;
                        dump_data_q  <= '0;
                        dump_valid_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    // Captured word holds while ready is low; the index ends
                    // at the last address instead of rolling over.
                    if (dump_valid_q && bus.i_dump_ready) begin
                        if (dump_addr_q == LAST_IDX) begin
                            dump_valid_q <= 1'b0;
                            dump_done_q  <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            dump_addr_q <= dump_addr_d;
                            dump_data_q <= dump_data_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_dump_valid = dump_valid_q;
    assign bus.o_dump_addr  = dump_addr_q;
    assign bus.o_dump_data  = dump_data_q;
    assign bus.o_dump_done  = dump_done_q;
    assign bus.o_dump_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_id_regbank.sv
// -----------------------------------------------------------------------------
// tb_id_regbank
// Self-checking bench for id_regbank (NB_REG=32, NB_ADDR=5, NUM_RD=2).
// A reference array mirrors every committed write; expected dump words are
// pushed to a queue when a dump is started and popped as the DUT offers them.
// Inputs change on the falling edge, outputs are sampled on the falling edge
// (registered) or 1 time unit after an input change (combinational).
// -----------------------------------------------------------------------------
module tb_id_regbank;
    localparam int NB_REG  = 32;
    localparam int NB_ADDR = 5;
    localparam int NUM_RD  = 2;
    localparam int DEPTH   = 2 ** NB_ADDR;

    typedef struct packed {
        logic [NB_ADDR-1:0] addr;
        logic [NB_REG-1:0]  data;
    } dump_exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [NB_REG-1:0] model [DEPTH];
    dump_exp_t         sb_q[$];

    id_regbank_if #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .NUM_RD(NUM_RD)) bus ();

    id_regbank #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .NUM_RD(NUM_RD)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pushes the expected stream for a full dump from the reference array.
    task automatic push_dump_expect();
        dump_exp_t e;
        sb_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            e.addr = a[NB_ADDR-1:0];
            e.data = model[a];
            sb_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.i_dunit_clk_en = 1'b0;
        bus.i_wr_en        = 1'b0;
        bus.i_wr_addr      = '0;
        bus.i_wr_data      = '0;
        bus.i_rd_addr      = '0;
        bus.i_dump_start   = 1'b0;
        bus.i_dump_ready   = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got v/b/d=%b%b%b want 000",
                     bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done);
        end
        checks++;
        if (bus.o_dump_addr !== '0 || bus.o_dump_data !== '0) begin
            errors++;
            $display("FAIL reset_dump_word: got addr=%0d data=%h want 0/0",
                     bus.o_dump_addr, bus.o_dump_data);
        end
        checks++;
        if (bus.o_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_r0: got %h want 0", bus.o_rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        bus.i_dunit_clk_en = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_addr = i[NB_ADDR-1:0];
            bus.i_wr_data = 32'hDEADBEEF + i;
            model[i]      = 32'hDEADBEEF + i;
            @(negedge clk);
        end
        // Write to register 0 must be dropped, bypass included.
        bus.i_wr_addr = '0;
        bus.i_wr_data = 32'hFFFF_FFFF;
        bus.i_rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (bus.o_rd_data !== '0) begin
            errors++;
            $display("FAIL r0_bypass: got %h want 0", bus.o_rd_data);
        end
        @(negedge clk);
        bus.i_wr_en = 1'b0;
        #1;
        checks++;
        if (bus.o_rd_data !== '0) begin
            errors++;
            $display("FAIL r0_stored: got %h want 0", bus.o_rd_data);
        end
        bus.i_rd_addr = {5'd2, 5'd1};
        #1;
        checks++;
        if (bus.o_rd_data !== {32'hDEADBEF1, 32'hDEADBEF0}) begin
            errors++;
            $display("FAIL rd_1_2: got %h want deadbef1deadbef0", bus.o_rd_data);
        end
        bus.i_rd_addr = {5'd31, 5'd0};
        #1;
        checks++;
        if (bus.o_rd_data !== {32'hDEADBF0E, 32'h0}) begin
            errors++;
            $display("FAIL rd_0_31: got %h want deadbf0e00000000", bus.o_rd_data);
        end
    endtask

    task automatic test_gating_bypass();
        @(negedge clk);
        bus.i_rd_addr      = {5'd5, 5'd5};
        bus.i_dunit_clk_en = 1'b0;
        bus.i_wr_en        = 1'b1;
        bus.i_wr_addr      = 5'd5;
        bus.i_wr_data      = 32'h1234_5678;
        #1;
        checks++;
        if (bus.o_rd_data[31:0] !== model[5]) begin
            errors++;
            $display("FAIL gated_no_bypass: got %h want %h", bus.o_rd_data[31:0], model[5]);
        end
        @(negedge clk);
        bus.i_wr_en = 1'b0;
        #1;
        checks++;
        if (bus.o_rd_data[31:0] !== model[5]) begin
            errors++;
            $display("FAIL gated_no_store: got %h want %h", bus.o_rd_data[31:0], model[5]);
        end
        @(negedge clk);
        bus.i_dunit_clk_en = 1'b1;
        bus.i_wr_en        = 1'b1;
        #1;
        checks++;
        if (bus.o_rd_data !== {32'h1234_5678, 32'h1234_5678}) begin
            errors++;
            $display("FAIL bypass_both_ports: got %h want 1234567812345678", bus.o_rd_data);
        end
        @(negedge clk);
        model[5]    = 32'h1234_5678;
        bus.i_wr_en = 1'b0;
        #1;
        checks++;
        if (bus.o_rd_data[63:32] !== model[5]) begin
            errors++;
            $display("FAIL stored_after_write: got %h want %h", bus.o_rd_data[63:32], model[5]);
        end
        // Restore so the dump tests see the original ramp.
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = 32'hDEADBEF4;
        model[5]      = 32'hDEADBEF4;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
    endtask

    task automatic test_full_dump();
        dump_exp_t e;
        bus.i_dump_ready = 1'b1;
        bus.i_dump_start = 1'b1;
        push_dump_expect();
        @(negedge clk);
        bus.i_dump_start = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            checks++;
            if (bus.o_dump_valid !== 1'b1 || bus.o_dump_done !== 1'b0 || bus.o_dump_busy !== 1'b1) begin
                errors++;
                $display("FAIL full_flags[%0d]: got v/d/b=%b%b%b want 101", c,
                         bus.o_dump_valid, bus.o_dump_done, bus.o_dump_busy);
            end
            e = sb_q.pop_front();
            checks++;
            if (bus.o_dump_addr !== e.addr || bus.o_dump_data !== e.data) begin
                errors++;
                $display("FAIL full_word[%0d]: got %0d/%h want %0d/%h", c,
                         bus.o_dump_addr, bus.o_dump_data, e.addr, e.data);
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.o_dump_done, bus.o_dump_valid, bus.o_dump_busy} !== 3'b101) begin
            errors++;
            $display("FAIL full_done: got d/v/b=%b%b%b want 101",
                     bus.o_dump_done, bus.o_dump_valid, bus.o_dump_busy);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_dump_done, bus.o_dump_busy} !== 2'b00) begin
            errors++;
            $display("FAIL full_idle: got d/b=%b%b want 00", bus.o_dump_done, bus.o_dump_busy);
        end
    endtask

    task automatic test_backpressure();
        dump_exp_t e;
        int got    = 0;
        int stall  = 0;
        int budget = 0;
        bus.i_dump_ready = 1'b1;
        bus.i_dump_start = 1'b1;
        push_dump_expect();
        @(negedge clk);
        bus.i_dump_start = 1'b0;
        while (got < DEPTH && budget < 100) begin
            budget++;
            checks++;
            if (bus.o_dump_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_valid: got %b want 1 (word %0d)", bus.o_dump_valid, got);
            end
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL bp_queue: scoreboard empty at word %0d", got);
                break;
            end
            e = sb_q[0];
            checks++;
            if (bus.o_dump_addr !== e.addr || bus.o_dump_data !== e.data) begin
                errors++;
                $display("FAIL bp_word: got %0d/%h want %0d/%h",
                         bus.o_dump_addr, bus.o_dump_data, e.addr, e.data);
            end
            if (e.addr == 5'd7 && stall < 3) begin
                bus.i_dump_ready = 1'b0;
                // First stall cycle: overwrite reg 7 and pulse start; neither
                // may disturb the held word or the running dump.
                bus.i_wr_en      = (stall == 0);
                bus.i_wr_addr    = 5'd7;
                bus.i_wr_data    = 32'hCAFE_F00D;
                bus.i_dump_start = (stall == 0);
                if (stall == 0) model[7] = 32'hCAFE_F00D;
                stall++;
            end else begin
                bus.i_dump_ready = 1'b1;
                bus.i_wr_en      = 1'b0;
                bus.i_dump_start = 1'b0;
                void'(sb_q.pop_front());
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != DEPTH || stall != 3) begin
            errors++;
            $display("FAIL bp_progress: got %0d words %0d stalls want %0d/3", got, stall, DEPTH);
        end
        checks++;
        if ({bus.o_dump_done, bus.o_dump_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_done: got d/v=%b%b want 10", bus.o_dump_done, bus.o_dump_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_dump_busy, bus.o_dump_valid} !== 2'b00) begin
            errors++;
            $display("FAIL bp_start_ignored: got b/v=%b%b want 00", bus.o_dump_busy, bus.o_dump_valid);
        end
    endtask

    task automatic test_reset_mid_dump();
        dump_exp_t e;
        int budget = 0;
        bus.i_dump_ready = 1'b1;
        bus.i_dump_start = 1'b1;
        push_dump_expect();
        @(negedge clk);
        bus.i_dump_start = 1'b0;
        while (bus.o_dump_addr != 5'd10 && budget < 40) begin
            budget++;
            e = sb_q.pop_front();
            checks++;
            if (bus.o_dump_valid !== 1'b1 || bus.o_dump_addr !== e.addr || bus.o_dump_data !== e.data) begin
                errors++;
                $display("FAIL rst_pre_word: got v=%b %0d/%h want 1 %0d/%h", bus.o_dump_valid,
                         bus.o_dump_addr, bus.o_dump_data, e.addr, e.data);
            end
            @(negedge clk);
        end
        checks++;
        if (budget >= 40) begin
            errors++;
            $display("FAIL rst_reach_10: timeout, addr=%0d want 10", bus.o_dump_addr);
        end
        sb_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_abort: got v/b/d=%b%b%b want 000",
                     bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.o_dump_done, bus.o_dump_busy} !== 2'b00) begin
                errors++;
                $display("FAIL rst_no_done: got d/b=%b%b want 00", bus.o_dump_done, bus.o_dump_busy);
            end
        end
`ifdef REGBANK_RESET_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
        for (int i = 1; i < DEPTH; i++) begin
            bus.i_rd_addr = {i[NB_ADDR-1:0], i[NB_ADDR-1:0]};
            #1;
            checks++;
            if (bus.o_rd_data !== {model[i], model[i]}) begin
                errors++;
                $display("FAIL rst_contents[%0d]: got %h want %h", i, bus.o_rd_data[31:0], model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_gating_bypass();
        test_full_dump();
        test_backpressure();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
